// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the memory arbiter: FSM state encoding,
// port indices and a small helper that turns a port index into a one-hot grant.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DMA = 1'b1;

   function automatic logic [1:0] port_onehot(input logic port);
      return port ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: a lone requester wins outright,
// and on contention the port that did not win last time takes the grant.
module rr_pick2
   import mem_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic       winner,
   output logic       valid
);

   always_comb begin
      valid  = |req;
      winner = PORT_CPU;
      case (req)
         2'b01:   winner = PORT_CPU;
         2'b10:   winner = PORT_DMA;
         2'b11:   winner = ~last;
         default: winner = PORT_CPU;
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single memory_bus port between the CPU (port 0) and the DMA/loader
// (port 1): latches one request, holds it on the bus for BUS_LATENCY clocks, then acks.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int BUS_LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_0,
   input  logic        req_1,
   input  logic        we_0,
   input  logic        we_1,
   input  logic [15:0] addr_0,
   input  logic [15:0] addr_1,
   input  logic [7:0]  wdata_0,
   input  logic [7:0]  wdata_1,
   output logic        ack_0,
   output logic        ack_1,
   output logic [7:0]  rdata,
   output logic [1:0]  grant,
   output logic        busy,
   output logic [15:0] bus_address,
   output logic [7:0]  bus_data_in,
   output logic        bus_write_enable,
   input  logic [7:0]  bus_data_out
);

   state_t      state;
   state_t      state_next;
   logic [2:0]  cnt;
   logic        last;
   logic        owner;
   logic        acc_we;
   logic        pick_winner;
   logic        pick_valid;
   logic        cnt_done;

   rr_pick2 u_pick (
      .req    ({req_1, req_0}),
      .last   (last),
      .winner (pick_winner),
      .valid  (pick_valid)
   );

   assign cnt_done = (cnt == 3'(BUS_LATENCY - 1));

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:   if (pick_valid) state_next = ST_ACCESS;
         ST_ACCESS: if (cnt_done) state_next = ST_DONE;
         ST_DONE:   state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   // The write strobe and ack are self-clearing, so each lasts exactly one cycle;
   // the bus address/data keep their last value while idle.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt              <= '0;
         last             <= PORT_DMA;
         owner            <= PORT_CPU;
         acc_we           <= 1'b0;
         ack_0            <= 1'b0;
         ack_1            <= 1'b0;
         rdata            <= '0;
         grant            <= '0;
         busy             <= 1'b0;
         bus_address      <= '0;
         bus_data_in      <= '0;
         bus_write_enable <= 1'b0;
      end else begin
         ack_0            <= 1'b0;
         ack_1            <= 1'b0;
         bus_write_enable <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (pick_valid) begin
                  bus_address      <= pick_winner ? addr_1 : addr_0;
                  bus_data_in      <= pick_winner ? wdata_1 : wdata_0;
                  bus_write_enable <= pick_winner ? we_1 : we_0;
                  acc_we           <= pick_winner ? we_1 : we_0;
                  owner            <= pick_winner;
                  last             <= pick_winner;
                  grant            <= port_onehot(pick_winner);
                  busy             <= 1'b1;
                  cnt              <= '0;
               end
            end
            ST_ACCESS: begin
               cnt <= cnt + 3'd1;
               if (cnt_done) begin
                  if (!acc_we) rdata <= bus_data_out;
                  ack_0 <= (owner == PORT_CPU);
                  ack_1 <= (owner == PORT_DMA);
               end
            end
            ST_DONE: begin
               grant <= '0;
               busy  <= 1'b0;
            end
            default: begin
               grant <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes the expected ack (port, cycle, data)
// into a queue and a negedge monitor pops and compares whenever an ack appears.
module tb_mem_arbiter;

   localparam int BUS_LATENCY = 2;
   localparam int ACK_DELAY   = BUS_LATENCY + 1;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_0, req_1, we_0, we_1;
   logic [15:0] addr_0, addr_1;
   logic [7:0]  wdata_0, wdata_1;
   logic        ack_0, ack_1;
   logic [7:0]  rdata;
   logic [1:0]  grant;
   logic        busy;
   logic [15:0] bus_address;
   logic [7:0]  bus_data_in;
   logic        bus_write_enable;
   logic [7:0]  bus_data_out;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      logic        port;
      int          cyc;
      logic [7:0]  rdata;
      logic [15:0] addr;
      logic        is_write;
      logic [7:0]  wdata;
   } exp_t;

   exp_t sbq[$];

   int          strobeCount = 0;
   logic [15:0] strobeAddr  = '0;
   logic [7:0]  strobeData  = '0;

   mem_arbiter #(.BUS_LATENCY(BUS_LATENCY)) dut (
      .clk              (clk),
      .reset            (reset),
      .req_0            (req_0),
      .req_1            (req_1),
      .we_0             (we_0),
      .we_1             (we_1),
      .addr_0           (addr_0),
      .addr_1           (addr_1),
      .wdata_0          (wdata_0),
      .wdata_1          (wdata_1),
      .ack_0            (ack_0),
      .ack_1            (ack_1),
      .rdata            (rdata),
      .grant            (grant),
      .busy             (busy),
      .bus_address      (bus_address),
      .bus_data_in      (bus_data_in),
      .bus_write_enable (bus_write_enable),
      .bus_data_out     (bus_data_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: 0x4000-0x7FFF is ROM holding 0xC0 | addr[3:0], the rest is RAM.
   bit [7:0] ram [0:65535];

   function automatic logic [7:0] romByte(input logic [15:0] a);
      return 8'hC0 | {4'h0, a[3:0]};
   endfunction

   assign bus_data_out = (bus_address[15:14] == 2'b01) ? romByte(bus_address) : ram[bus_address];

   always @(posedge clk) begin
      if (bus_write_enable && bus_address[15:14] != 2'b01) ram[bus_address] <= bus_data_in;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (bus_write_enable === 1'b1) begin
         strobeCount++;
         strobeAddr = bus_address;
         strobeData = bus_data_in;
      end
      if (ack_0 === 1'b1 || ack_1 === 1'b1) begin
         if (sbq.size() == 0) begin
            checkOutput("unexpected_ack", {30'd0, ack_1, ack_0}, 32'd0);
         end else begin
            e = sbq.pop_front();
            checkOutput("ack_port", {30'd0, ack_1, ack_0}, {30'd0, (e.port ? 2'b10 : 2'b01)});
            checkOutput("ack_cycle", cyc, e.cyc);
            checkOutput("ack_grant", {30'd0, grant}, {30'd0, (e.port ? 2'b10 : 2'b01)});
            checkOutput("ack_rdata", {24'd0, rdata}, {24'd0, e.rdata});
            checkOutput("ack_bus_address", {16'd0, bus_address}, {16'd0, e.addr});
            if (e.is_write) checkOutput("ack_bus_data_in", {24'd0, bus_data_in}, {24'd0, e.wdata});
         end
      end
   end

   function automatic exp_t mkExp(input logic port, input int at, input logic [7:0] rd,
                                  input logic [15:0] addr, input logic we, input logic [7:0] wd);
      exp_t e;
      e.port = port; e.cyc = at; e.rdata = rd; e.addr = addr; e.is_write = we; e.wdata = wd;
      return e;
   endfunction

   task automatic applyStimulus(input logic port, input logic we, input logic [15:0] addr,
                                input logic [7:0] wdata, input logic [7:0] expRdata, input bit expectAck);
      @(negedge clk);
      if (port) begin
         req_1 = 1'b1; we_1 = we; addr_1 = addr; wdata_1 = wdata;
      end else begin
         req_0 = 1'b1; we_0 = we; addr_0 = addr; wdata_0 = wdata;
      end
      if (expectAck) sbq.push_back(mkExp(port, cyc + ACK_DELAY, expRdata, addr, we, wdata));
   endtask

   task automatic waitAck(input logic port);
      bit seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if ((port == 1'b0 && ack_0 === 1'b1) || (port == 1'b1 && ack_1 === 1'b1)) seen = 1;
      end
      if (!seen) checkOutput("ack_timeout", 32'd0, 32'd1);
      if (port) req_1 = 1'b0;
      else      req_0 = 1'b0;
   endtask

   initial begin
      int strobeBefore;
      int acks;
      reset = 1'b1;
      req_0 = 1'b1; req_1 = 1'b1;
      we_0 = 1'b0; we_1 = 1'b0;
      addr_0 = 16'h0012; addr_1 = 16'h0040;
      wdata_0 = 8'h00; wdata_1 = 8'h00;

      // Reset held with both ports requesting: everything stays quiet.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("reset_outputs",
                     {3'd0, ack_0, ack_1, rdata, grant, busy, bus_write_enable, bus_address},
                     32'd0);
         checkOutput("reset_bus_data_in", {24'd0, bus_data_in}, 32'd0);
      end
      sbq.push_back(mkExp(1'b0, cyc + ACK_DELAY, 8'h00, 16'h0012, 1'b0, 8'h00));
      reset = 1'b0;
      waitAck(1'b0);
      req_1 = 1'b0;

      // CPU write then read-back.
      strobeBefore = strobeCount;
      applyStimulus(1'b0, 1'b1, 16'h0012, 8'hA5, 8'h00, 1'b1);
      waitAck(1'b0);
      checkOutput("cpu_write_strobes", strobeCount, strobeBefore + 1);
      checkOutput("cpu_write_strobe_addr", {16'd0, strobeAddr}, 32'h0012);
      checkOutput("cpu_write_strobe_data", {24'd0, strobeData}, 32'hA5);
      applyStimulus(1'b0, 1'b0, 16'h0012, 8'h00, 8'hA5, 1'b1);
      waitAck(1'b0);

      // DMA write to a peripheral address leaves rdata alone.
      strobeBefore = strobeCount;
      applyStimulus(1'b1, 1'b1, 16'h8001, 8'h3C, 8'hA5, 1'b1);
      waitAck(1'b1);
      checkOutput("dma_write_strobes", strobeCount, strobeBefore + 1);
      checkOutput("dma_write_strobe_addr", {16'd0, strobeAddr}, 32'h8001);

      // Contention: both ports held for four accesses, grants must alternate starting at port 0.
      @(negedge clk);
      req_0 = 1'b1; we_0 = 1'b0; addr_0 = 16'h0012;
      req_1 = 1'b1; we_1 = 1'b0; addr_1 = 16'h4005;
      sbq.push_back(mkExp(1'b0, cyc + 3,  8'hA5, 16'h0012, 1'b0, 8'h00));
      sbq.push_back(mkExp(1'b1, cyc + 7,  8'hC5, 16'h4005, 1'b0, 8'h00));
      sbq.push_back(mkExp(1'b0, cyc + 11, 8'hA5, 16'h0012, 1'b0, 8'h00));
      sbq.push_back(mkExp(1'b1, cyc + 15, 8'hC5, 16'h4005, 1'b0, 8'h00));
      acks = 0;
      for (int i = 0; i < 40 && acks < 4; i++) begin
         @(negedge clk);
         if (ack_0 === 1'b1 || ack_1 === 1'b1) acks++;
      end
      if (acks < 4) checkOutput("contention_ack_timeout", acks, 4);
      req_0 = 1'b0; req_1 = 1'b0;

      // Reset during the first ACCESS cycle of a read aborts it without an ack.
      applyStimulus(1'b0, 1'b0, 16'h0013, 8'h00, 8'h00, 1'b0);
      @(negedge clk);
      checkOutput("abort_busy_before", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      req_0 = 1'b0;
      @(negedge clk);
      checkOutput("abort_busy", {31'd0, busy}, 32'd0);
      checkOutput("abort_grant", {30'd0, grant}, 32'd0);
      checkOutput("abort_we", {31'd0, bus_write_enable}, 32'd0);
      checkOutput("abort_rdata", {24'd0, rdata}, 32'd0);
      reset = 1'b0;
      repeat (6) @(negedge clk);

      // One-cycle request pulse from the CPU to ROM still completes once.
      applyStimulus(1'b0, 1'b0, 16'h4005, 8'h00, 8'hC5, 1'b1);
      @(negedge clk);
      req_0 = 1'b0;
      waitAck(1'b0);
      repeat (4) @(negedge clk);
      checkOutput("pulse_no_regrant_grant", {30'd0, grant}, 32'd0);
      checkOutput("pulse_no_regrant_busy", {31'd0, busy}, 32'd0);

      checkOutput("scoreboard_drained", sbq.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
